// File: rtl/sw_debounce_sync.sv
// Switch conditioner: per-bit synchronizer, debounce FSM, edge pulses
// and a saturating change-event counter for the HPS switch PIO.
module sw_debounce_sync #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int EVT_W           = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  input  logic             event_clr,
  output logic [EVT_W-1:0] event_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sw_sync;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  always_comb begin
    sync_d[0] = sw_raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sw_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_STABLE: begin
          if (sw_sync[i] != deb_q[i]) begin
            state_d[i] = ST_PENDING;
            cnt_d[i]   = CW'(1);
          end else begin
            cnt_d[i]   = '0;
          end
        end
        ST_PENDING: begin
          if (sw_sync[i] == deb_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            deb_d[i]   = sw_sync[i];
            rise_d[i]  = sw_sync[i];
            fall_d[i]  = ~sw_sync[i];
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
      endcase
    end
    chg_d = |{rise_d, fall_d};
  end

  // clear beats a simultaneous increment; the event is dropped
  always_comb begin
    evt_d = evt_q;
    if (event_clr) begin
      evt_d = '0;
    end else if (chg_q && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
      evt_q  <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
      evt_q  <= evt_d;
    end
  end

  assign sw_debounced = deb_q;
  assign sw_rise      = rise_q;
  assign sw_fall      = fall_q;
  assign sw_changed   = chg_q;
  assign event_count  = evt_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_sw_debounce_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw = 4'b0000;
  logic       clr = 1'b0;
  logic [3:0] deb, rise, fall;
  logic       chg;
  logic [7:0] evt;

  int total = 0;
  int bad = 0;
  logic act;

  sw_debounce_sync #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .EVT_W(8)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .sw_raw(raw),
    .sw_debounced(deb),
    .sw_rise(rise),
    .sw_fall(fall),
    .sw_changed(chg),
    .event_clr(clr),
    .event_count(evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // step n cycles, flagging any pulse or a deb value other than dexp
  task automatic watch(input int n, input logic [3:0] dexp);
    for (int k = 0; k < n; k++) begin
      step(1);
      if (chg || (|rise) || (|fall) || (deb !== dexp)) act = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] evt0;
    act = 1'b0;

    // reset state
    #3;
    chk("rst_deb", {28'b0, deb}, 32'h0);
    chk("rst_rise", {28'b0, rise}, 32'h0);
    chk("rst_fall", {28'b0, fall}, 32'h0);
    chk("rst_chg", {31'b0, chg}, 32'h0);
    chk("rst_evt", {24'b0, evt}, 32'h0);
    #10 rst_n = 1'b1;
    step(2);

    // 1: clean step
    raw = 4'b0001;
    step(10);
    chk("t1_deb_early", {28'b0, deb}, 32'h0);
    step(1);
    chk("t1_deb", {28'b0, deb}, 32'h1);
    chk("t1_rise", {28'b0, rise}, 32'h1);
    chk("t1_chg", {31'b0, chg}, 32'h1);
    step(1);
    chk("t1_rise_off", {28'b0, rise}, 32'h0);
    chk("t1_chg_off", {31'b0, chg}, 32'h0);
    chk("t1_evt", {24'b0, evt}, 32'h1);

    // 2: bounce on bit 2, then settle high
    act = 1'b0;
    raw = 4'b0101; watch(3, 4'b0001);
    raw = 4'b0001; watch(3, 4'b0001);
    raw = 4'b0101; watch(3, 4'b0001);
    raw = 4'b0001; watch(3, 4'b0001);
    chk("t2_quiet", {31'b0, act}, 32'h0);
    raw = 4'b0101;
    step(10);
    chk("t2_deb_early", {28'b0, deb}, 32'h1);
    step(1);
    chk("t2_deb", {28'b0, deb}, 32'h5);
    chk("t2_rise", {28'b0, rise}, 32'h4);
    step(1);
    chk("t2_rise_off", {28'b0, rise}, 32'h0);
    chk("t2_evt", {24'b0, evt}, 32'h2);

    // 3: simultaneous bits
    raw = 4'b0000;
    step(11);
    chk("t3_fall_pre", {28'b0, fall}, 32'h5);
    chk("t3_chg_pre", {31'b0, chg}, 32'h1);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t3_clr", {24'b0, evt}, 32'h0);
    raw = 4'b1010;
    step(11);
    chk("t3_rise", {28'b0, rise}, 32'ha);
    chk("t3_fall0", {28'b0, fall}, 32'h0);
    chk("t3_chg", {31'b0, chg}, 32'h1);
    step(1);
    chk("t3_chg_off", {31'b0, chg}, 32'h0);
    chk("t3_evt1", {24'b0, evt}, 32'h1);
    raw = 4'b0000;
    step(11);
    chk("t3_fall", {28'b0, fall}, 32'ha);
    chk("t3_rise0", {28'b0, rise}, 32'h0);
    step(1);
    chk("t3_evt2", {24'b0, evt}, 32'h2);

    // 4: saturation, then clear against a live pulse
    for (int t = 0; t < 300; t++) begin
      raw[0] = ~raw[0];
      step(12);
      if (t == 252) chk("t4_evt_255", {24'b0, evt}, 32'hff);
    end
    chk("t4_sat", {24'b0, evt}, 32'hff);
    raw[0] = ~raw[0];
    step(11);
    chk("t4_chg", {31'b0, chg}, 32'h1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t4_clr", {24'b0, evt}, 32'h0);
    step(1);
    chk("t4_lost", {24'b0, evt}, 32'h0);
    chk("t4_deb", {28'b0, deb}, 32'h1);

    // 5: asynchronous reset mid-debounce
    raw = 4'b1111;
    step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_deb0", {28'b0, deb}, 32'h0);
    chk("t5_rise0", {28'b0, rise}, 32'h0);
    chk("t5_fall0", {28'b0, fall}, 32'h0);
    chk("t5_chg0", {31'b0, chg}, 32'h0);
    chk("t5_evt0", {24'b0, evt}, 32'h0);
    #20 rst_n = 1'b1;
    step(10);
    chk("t5_deb_early", {28'b0, deb}, 32'h0);
    step(1);
    chk("t5_deb", {28'b0, deb}, 32'hf);
    chk("t5_rise", {28'b0, rise}, 32'hf);
    step(1);
    chk("t5_rise_off", {28'b0, rise}, 32'h0);
    chk("t5_evt", {24'b0, evt}, 32'h1);

    // 6: one-cycle glitch on bit 3
    raw = 4'b0111;
    step(11);
    chk("t6_fall_pre", {28'b0, fall}, 32'h8);
    step(1);
    evt0 = evt;
    chk("t6_evt_pre", {24'b0, evt0}, 32'h2);
    #3 raw[3] = 1'b1;
    #10 raw[3] = 1'b0;
    act = 1'b0;
    watch(20, 4'b0111);
    chk("t6_quiet", {31'b0, act}, 32'h0);
    chk("t6_evt", {24'b0, evt}, {24'b0, evt0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
